lap_store: RTL and testbench

Lap-time register bank for the stopwatch. It is the responder to the control FSM's SAVE and RETRIEVE states. On a save request it captures the running stopwatch time as a new lap entry. On a retrieve request it returns stored laps one per request, oldest first, for the LCD path. While an operation is in progress it drives `busy`, which is the `reg_busy` stimulus seen by the control FSM.

---
 rtl/lap_store.sv | 169 ++++++++++++++++
 tb/tb_lap_store.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lap_store.sv
// Lap-time register bank: circular buffer of {epoch, m_epoch} words behind a small
// save / retrieve / clear sequencer. busy feeds the control FSM as reg_busy.
//
// state   | meaning
// IDLE    | waiting; requests sampled here only (clear > save > retrieve)
// WRITE   | registered word written at wr_ptr; overwrite oldest when full
// RD_ADDR | RAM addressed at (oldest + cursor)
// RD_DATA | RAM output captured into lap_*, lap_valid strobed, cursor advanced
// CLR     | DEPTH cycles zeroing addresses 0..DEPTH-1, pointers cleared on exit
module lap_store #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              save,
   input  logic              retrieve,
   input  logic              clear,
   input  logic [17:0]       epoch,
   input  logic [9:0]        m_epoch,
   output logic              busy,
   output logic              lap_valid,
   output logic [17:0]       lap_epoch,
   output logic [9:0]        lap_m_epoch,
   output logic [ADDR_W-1:0] lap_index,
   output logic [ADDR_W:0]   lap_count,
   output logic              full,
   output logic              empty
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, CLR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   oldest_q, oldest_d;
   logic [ADDR_W-1:0]   cursor_q, cursor_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [27:0]         word_q, word_d;
   logic                busy_q, busy_d;
   logic                lap_valid_q, lap_valid_d;
   logic [17:0]         lap_epoch_q, lap_epoch_d;
   logic [9:0]          lap_m_epoch_q, lap_m_epoch_d;
   logic [ADDR_W-1:0]   lap_index_q, lap_index_d;

   logic [27:0]         mem [DEPTH];
   logic [27:0]         rd_data_q;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [27:0]         mem_wdata;
   logic [ADDR_W-1:0]   rd_addr;
   logic                full_w, empty_w;

   assign full_w  = (count_q == (ADDR_W+1)'(DEPTH));
   assign empty_w = (count_q == '0);
   assign rd_addr = oldest_q + cursor_q;

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      oldest_d      = oldest_q;
      cursor_d      = cursor_q;
      clr_addr_d    = clr_addr_q;
      count_d       = count_q;
      word_d        = word_q;
      lap_valid_d   = 1'b0;
      lap_epoch_d   = lap_epoch_q;
      lap_m_epoch_d = lap_m_epoch_q;
      lap_index_d   = lap_index_q;
      mem_we        = 1'b0;
      mem_waddr     = wr_ptr_q;
      mem_wdata     = word_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               state_d    = CLR;
               clr_addr_d = '0;
            end else if (save) begin
               state_d = WRITE;
               word_d  = {epoch, m_epoch};
            end else if (retrieve && !empty_w) begin
               state_d = RD_ADDR;
            end
         end
         WRITE: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            cursor_d = '0;
            if (full_w) oldest_d = oldest_q + ADDR_W'(1);
            else        count_d  = count_q + (ADDR_W+1)'(1);
            state_d  = IDLE;
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            lap_epoch_d   = rd_data_q[27:10];
            lap_m_epoch_d = rd_data_q[9:0];
            lap_index_d   = cursor_q;
            lap_valid_d   = 1'b1;
            if (({1'b0, cursor_q} + (ADDR_W+1)'(1)) == count_q) cursor_d = '0;
            else                                              cursor_d = cursor_q + ADDR_W'(1);
            state_d       = IDLE;
         end
         CLR: begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdata  = '0;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == ADDR_W'(DEPTH-1)) begin
               state_d       = IDLE;
               wr_ptr_d      = '0;
               oldest_d      = '0;
               cursor_d      = '0;
               count_d       = '0;
               lap_epoch_d   = '0;
               lap_m_epoch_d = '0;
               lap_index_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         oldest_q      <= '0;
         cursor_q      <= '0;
         clr_addr_q    <= '0;
         count_q       <= '0;
         word_q        <= '0;
         busy_q        <= 1'b0;
         lap_valid_q   <= 1'b0;
         lap_epoch_q   <= '0;
         lap_m_epoch_q <= '0;
         lap_index_q   <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         oldest_q      <= oldest_d;
         cursor_q      <= cursor_d;
         clr_addr_q    <= clr_addr_d;
         count_q       <= count_d;
         word_q        <= word_d;
         busy_q        <= busy_d;
         lap_valid_q   <= lap_valid_d;
         lap_epoch_q   <= lap_epoch_d;
         lap_m_epoch_q <= lap_m_epoch_d;
         lap_index_q   <= lap_index_d;
      end
   end

   // Unreset RAM; stale contents stay unreachable through the pointers.
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data_q <= mem[rd_addr];
   end

   assign busy        = busy_q;
   assign lap_valid   = lap_valid_q;
   assign lap_epoch   = lap_epoch_q;
   assign lap_m_epoch = lap_m_epoch_q;
   assign lap_index   = lap_index_q;
   assign lap_count   = count_q;
   assign full        = full_w;
   assign empty       = empty_w;

endmodule

// File: tb/tb_lap_store.sv
// Directed bench for lap_store: reset, save/retrieve timing, cursor wrap,
// overwrite when full, request priority, empty retrieve and busy-time drops.
module tb_lap_store;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        save, retrieve, clear;
   logic [17:0] epoch;
   logic [9:0]  m_epoch;
   logic        busy, lap_valid, full, empty;
   logic [17:0] lap_epoch;
   logic [9:0]  lap_m_epoch;
   logic [2:0]  lap_index;
   logic [3:0]  lap_count;

   int checks = 0;
   int errors = 0;

   lap_store #(.DEPTH(8), .ADDR_W(3)) dut (
      .clock(clock), .reset_n(reset_n),
      .save(save), .retrieve(retrieve), .clear(clear),
      .epoch(epoch), .m_epoch(m_epoch),
      .busy(busy), .lap_valid(lap_valid),
      .lap_epoch(lap_epoch), .lap_m_epoch(lap_m_epoch), .lap_index(lap_index),
      .lap_count(lap_count), .full(full), .empty(empty)
   );

   always #10 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_save(input logic [17:0] ep, input logic [9:0] ms, input int exp_count);
      epoch = ep; m_epoch = ms; save = 1'b1;
      tick();
      save = 1'b0;
      chk("save_busy", busy, 1);
      tick();
      chk("save_busy_end", busy, 0);
      chk("save_count", lap_count, exp_count);
   endtask

   task automatic do_retrieve(input logic [17:0] e_ep, input logic [9:0] e_ms, input logic [2:0] e_idx);
      retrieve = 1'b1;
      tick();
      retrieve = 1'b0;
      chk("rd_busy1", busy, 1);
      chk("rd_valid_early", lap_valid, 0);
      tick();
      chk("rd_busy2", busy, 1);
      tick();
      chk("rd_valid", lap_valid, 1);
      chk("rd_busy_end", busy, 0);
      chk("rd_epoch", lap_epoch, e_ep);
      chk("rd_ms", lap_m_epoch, e_ms);
      chk("rd_index", lap_index, e_idx);
      tick();
      chk("rd_valid_pulse", lap_valid, 0);
      chk("rd_epoch_hold", lap_epoch, e_ep);
   endtask

   initial begin
      int n;
      reset_n = 1'b0; save = 1'b0; retrieve = 1'b0; clear = 1'b0;
      epoch = '0; m_epoch = '0;
      #5;
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", lap_count, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // 0:01:02.345
      do_save({6'd0, 6'd1, 6'd2}, 10'd345, 1);
      chk("empty_after_save", empty, 0);
      do_retrieve({6'd0, 6'd1, 6'd2}, 10'd345, 3'd0);

      // reset during RD_ADDR
      retrieve = 1'b1;
      tick();
      retrieve = 1'b0;
      chk("mid_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", lap_valid, 0);
      chk("mid_rst_epoch", lap_epoch, 0);
      #5 reset_n = 1'b1;
      tick();
      chk("post_rst_empty", empty, 1);
      chk("post_rst_count", lap_count, 0);
      chk("post_rst_ms", lap_m_epoch, 0);
      chk("post_rst_index", lap_index, 0);
      chk("post_rst_valid", lap_valid, 0);

      // cursor wrap over three laps
      do_save({6'd0, 6'd0, 6'd10}, 10'd100, 1);
      do_save({6'd0, 6'd0, 6'd11}, 10'd200, 2);
      do_save({6'd0, 6'd0, 6'd12}, 10'd300, 3);
      do_retrieve({6'd0, 6'd0, 6'd10}, 10'd100, 3'd0);
      do_retrieve({6'd0, 6'd0, 6'd11}, 10'd200, 3'd1);
      do_retrieve({6'd0, 6'd0, 6'd12}, 10'd300, 3'd2);
      do_retrieve({6'd0, 6'd0, 6'd10}, 10'd100, 3'd0);

      // all three requests at once: clear wins
      epoch = {6'd1, 6'd2, 6'd3}; m_epoch = 10'd999;
      save = 1'b1; retrieve = 1'b1; clear = 1'b1;
      tick();
      save = 1'b0; retrieve = 1'b0; clear = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) n++;
         tick();
      end
      chk("clr_busy_cycles", n, 8);
      chk("clr_empty", empty, 1);
      chk("clr_count", lap_count, 0);
      chk("clr_epoch", lap_epoch, 0);
      chk("clr_ms", lap_m_epoch, 0);

      // retrieve when empty is ignored
      n = 0;
      retrieve = 1'b1;
      tick();
      retrieve = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (busy || lap_valid) n++;
         tick();
      end
      chk("empty_rd_ignored", n, 0);

      // nine saves into eight slots
      for (int s = 1; s <= 9; s++)
         do_save({12'd0, 6'(s)}, 10'(s * 10), (s > 8) ? 8 : s);
      chk("ovw_full", full, 1);
      chk("ovw_count", lap_count, 8);
      for (int i = 0; i < 8; i++)
         do_retrieve({12'd0, 6'(i + 2)}, 10'((i + 2) * 10), 3'(i));

      // save pulsed during RD_DATA is dropped
      retrieve = 1'b1;
      tick();
      retrieve = 1'b0;
      tick();
      epoch = {6'd5, 6'd5, 6'd5}; m_epoch = 10'd555; save = 1'b1;
      tick();
      save = 1'b0;
      chk("drop_valid", lap_valid, 1);
      chk("drop_epoch", lap_epoch, {12'd0, 6'd2});
      chk("drop_index", lap_index, 0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy) n++;
         tick();
      end
      chk("drop_no_busy", n, 0);
      chk("drop_count", lap_count, 8);
      do_retrieve({12'd0, 6'd3}, 10'd30, 3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
